// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int WIDTH      = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // High-half ops (MULHU) and the remainder (REMU) live in the upper shift register.
  function automatic logic result_from_hi(md_op_e op);
    return (op == MD_MULHU) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/write-back bundle between the execute stage and the multiply/divide unit.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH      = mul_div_unit_pkg::WIDTH,
  parameter int REG_ADDR_W = mul_div_unit_pkg::REG_ADDR_W
);

  logic                  md_start;
  md_op_e                md_op;
  logic [WIDTH-1:0]      md_rs1;
  logic [WIDTH-1:0]      md_rs2;
  logic [REG_ADDR_W-1:0] md_rd;
  logic                  md_busy;
  logic                  md_done;
  logic                  md_we;
  logic [REG_ADDR_W-1:0] md_rd_out;
  logic [WIDTH-1:0]      md_result;

  modport master (
    output md_start, md_op, md_rs1, md_rs2, md_rd,
    input  md_busy, md_done, md_we, md_rd_out, md_result
  );

  modport slave (
    input  md_start, md_op, md_rs1, md_rs2, md_rd,
    output md_busy, md_done, md_we, md_rd_out, md_result
  );

endinterface

// File: rtl/mul_div_unit_step.sv
// One iteration of shift-add multiply or restoring divide over the shared {hi, lo} register pair.
module mul_div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] rs2,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;

  // Compute both algorithms' next values and select by operation class.
  always_comb begin
    // NOTE: every output gets a default first so no branch can leave one unassigned (no latch).
    hi_next = hi;
    lo_next = lo;
    addend  = lo[0] ? rs2 : {WIDTH{1'b0}};
    sum     = {1'b0, hi} + {1'b0, addend};
    // Shifted partial remainder needs one extra bit; after a restore it always fits back in WIDTH.
    rem_sh  = {hi, lo[WIDTH-1]};
    rem_sub = rem_sh[WIDTH-1:0] - rs2;
    if (is_div) begin
      if (rem_sh >= {1'b0, rs2}) begin
        hi_next = rem_sub;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_sh[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU execute stage with register-file write-back outputs.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH      = mul_div_unit_pkg::WIDTH,
  parameter int REG_ADDR_W = mul_div_unit_pkg::REG_ADDR_W
) (
  input logic           clock,
  input logic           reset,
  mul_div_unit_if.slave md
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      count_q;
  md_op_e                op_q;
  logic [WIDTH-1:0]      rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [WIDTH-1:0]      hi_q, lo_q;
  logic [WIDTH-1:0]      hi_next, lo_next;
  logic [WIDTH-1:0]      result_q;
  logic [REG_ADDR_W-1:0] rd_out_q;
  logic                  last_iter;

  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  mul_div_unit_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_q[1]),
    .hi      (hi_q),
    .lo      (lo_q),
    .rs2     (rs2_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Next-state logic: accept only in IDLE, run WIDTH iterations, pulse DONE for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md.md_start) state_d = MD_RUN;
      MD_RUN:  if (last_iter)   state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // Operand capture, iteration datapath and write-back result registers.
  always_ff @(posedge clock) begin
    // NOTE: the datapath is cleared on reset as well, so an aborted operation leaves nothing behind.
    if (reset) begin
      count_q  <= '0;
      op_q     <= MD_MUL;
      rs2_q    <= '0;
      rd_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md.md_start) begin
            op_q    <= md.md_op;
            rs2_q   <= md.md_rs2;
            rd_q    <= md.md_rd;
            hi_q    <= '0;
            lo_q    <= md.md_rs1;
            count_q <= '0;
          end
        end
        MD_RUN: begin
          hi_q    <= hi_next;
          lo_q    <= lo_next;
          count_q <= count_q + CNT_W'(1);
          if (last_iter) begin
            result_q <= result_from_hi(op_q) ? hi_next : lo_next;
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign md.md_busy   = (state_q != MD_IDLE);
  assign md.md_done   = (state_q == MD_DONE);
  assign md.md_we     = (state_q == MD_DONE);
  assign md.md_rd_out = rd_out_q;
  assign md.md_result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench: a small register file feeds operands and receives write-backs.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  typedef struct {
    logic [REG_ADDR_W-1:0] rd;
    logic [WIDTH-1:0]      res;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  // Register file: one bench write port, one write-back port, two read ports.
  logic [WIDTH-1:0]      rf [32];
  logic                  tb_we;
  logic [REG_ADDR_W-1:0] tb_wa;
  logic [WIDTH-1:0]      tb_wd;
  logic [REG_ADDR_W-1:0] rg_a1, rg_a2;
  logic [WIDTH-1:0]      rg_rd1, rg_rd2;

  mul_div_unit_if md_if ();

  mul_div_unit dut (
    .clock (clock),
    .reset (reset),
    .md    (md_if)
  );

  always #5 clock = ~clock;

  assign rg_rd1       = rf[rg_a1];
  assign rg_rd2       = rf[rg_a2];
  assign md_if.md_rs1 = rg_rd1;
  assign md_if.md_rs2 = rg_rd2;

  // Register file writes; x0 stays hard-wired to zero.
  always @(posedge clock) begin
    if (tb_we) rf[tb_wa] <= tb_wd;
    if (md_if.md_we === 1'b1 && md_if.md_rd_out != '0) rf[md_if.md_rd_out] <= md_if.md_result;
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] model(input md_op_e op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      MD_MUL:   return p[WIDTH-1:0];
      MD_MULHU: return p[2*WIDTH-1:WIDTH];
      MD_DIVU:  return (b == '0) ? {WIDTH{1'b1}} : a / b;
      default:  return (b == '0) ? a : a % b;
    endcase
  endfunction

  // Completion monitor: every done must match the oldest outstanding request.
  always @(negedge clock) begin
    if (md_if.md_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", md_if.md_result, e.res);
        check("rd_out", WIDTH'(md_if.md_rd_out), WIDTH'(e.rd));
        check("we", WIDTH'(md_if.md_we), 1);
      end
    end
  end

  // Called on a negedge; returns on the negedge after the write.
  task automatic write_reg(input logic [REG_ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    tb_wa = a;
    tb_wd = d;
    tb_we = 1'b1;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  // Full operation through the register file. inj_run pokes md_start (with a different op)
  // at that iteration; inj_done pokes md_start during the DONE cycle.
  task automatic run_op(input md_op_e op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [REG_ADDR_W-1:0] rd, input int inj_run, input bit inj_done);
    int lat;
    exp_t e;
    write_reg(5'd1, a);
    write_reg(5'd2, b);
    rg_a1 = 5'd1;
    rg_a2 = 5'd2;
    md_if.md_op    = op;
    md_if.md_rd    = rd;
    md_if.md_start = 1'b1;
    e.rd  = rd;
    e.res = model(op, a, b);
    sb.push_back(e);
    @(negedge clock);                 // accept edge has passed
    md_if.md_start = 1'b0;
    check("busy_after_accept", WIDTH'(md_if.md_busy), 1);
    lat = 0;
    while (md_if.md_done !== 1'b1 && lat < WIDTH + 8) begin
      @(negedge clock);
      lat++;
      if (lat == inj_run) begin
        md_if.md_start = 1'b1;
        md_if.md_op    = MD_DIVU;
      end else if (lat == inj_run + 1) begin
        md_if.md_start = 1'b0;
        md_if.md_op    = op;
      end
    end
    // done is high in the cycle after the WIDTH-th RUN edge
    check("latency", WIDTH'(lat), WIDTH'(WIDTH));
    if (inj_done) md_if.md_start = 1'b1;
    @(negedge clock);
    md_if.md_start = 1'b0;
    check("idle_after_done", WIDTH'(md_if.md_busy), 0);
    rg_a1 = rd;
    #1;
    check("writeback", rg_rd1, e.res);
  endtask

  typedef struct {
    md_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset          = 1'b1;
    tb_we          = 1'b0;
    tb_wa          = '0;
    tb_wd          = '0;
    rg_a1          = '0;
    rg_a2          = '0;
    md_if.md_start = 1'b1;
    md_if.md_op    = MD_MUL;
    md_if.md_rd    = 5'd5;

    // Reset held with a pending request: nothing may be accepted.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", WIDTH'(md_if.md_busy), 0);
    check("rst_done", WIDTH'(md_if.md_done), 0);
    check("rst_we", WIDTH'(md_if.md_we), 0);
    check("rst_result", md_if.md_result, 0);
    check("rst_rd_out", WIDTH'(md_if.md_rd_out), 0);
    md_if.md_start = 1'b0;
    reset          = 1'b0;
    @(negedge clock);
    check("idle_after_rst", WIDTH'(md_if.md_busy), 0);

    // Directed corner cases followed by a few random operands.
    vecs.push_back('{MD_MUL,   32'd7,          32'd6});
    vecs.push_back('{MD_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF});
    vecs.push_back('{MD_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF});
    vecs.push_back('{MD_MULHU, 32'h0001_0000,  32'h0001_0000});
    vecs.push_back('{MD_DIVU,  32'd1000,       32'd7});
    vecs.push_back('{MD_REMU,  32'd1000,       32'd7});
    vecs.push_back('{MD_DIVU,  32'd5,          32'd9});
    vecs.push_back('{MD_REMU,  32'd5,          32'd9});
    vecs.push_back('{MD_DIVU,  32'd1234,       32'd0});
    vecs.push_back('{MD_REMU,  32'd1234,       32'd0});
    vecs.push_back('{MD_DIVU,  32'hFFFF_FFFF,  32'h8000_0001});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{md_op_e'(i), $urandom, (i > 1) ? $urandom_range(1, 65535) : $urandom});

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'd5 + 5'(i % 8), -1, 1'b0);

    // Starts during RUN and DONE are ignored: exactly one completion, correct result.
    run_op(MD_MUL, 32'd100, 32'd200, 5'd6, 3, 1'b1);
    repeat (3) @(negedge clock);
    check("no_requeue", WIDTH'(md_if.md_busy), 0);

    // Reset in the middle of a divide aborts it without a write-back.
    write_reg(5'd9, 32'h0000_A5A5);
    write_reg(5'd1, 32'd500);
    write_reg(5'd2, 32'd3);
    rg_a1          = 5'd1;
    rg_a2          = 5'd2;
    md_if.md_op    = MD_DIVU;
    md_if.md_rd    = 5'd9;
    md_if.md_start = 1'b1;
    @(negedge clock);
    md_if.md_start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", WIDTH'(md_if.md_busy), 0);
    check("abort_done", WIDTH'(md_if.md_done), 0);
    check("abort_result", md_if.md_result, 0);
    repeat (WIDTH + 4) @(negedge clock);
    check("abort_still_idle", WIDTH'(md_if.md_busy), 0);
    rg_a1 = 5'd9;
    #1;
    check("abort_no_write", rg_rd1, 32'h0000_A5A5);
    @(negedge clock);

    run_op(MD_MUL, 32'd3, 32'd3, 5'd10, -1, 1'b0);

    repeat (2) @(negedge clock);
    check("sb_empty", WIDTH'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
